// File: rtl/muldiv_controller.sv
// muldiv_controller: sequences one HI/LO-class op at a time onto the shared
// Booth multiplier / divider, waits a fixed latency and commits the 64-bit
// result into the architectural HI/LO registers.
// Optional feature macro: MULDIV_DIVZERO_CHECK_EN (short-circuits DIV by zero
// through a one-cycle DZERO state instead of running the divider).
module muldiv_controller #(
    parameter int MULT_CYCLES = 33,
    parameter int DIV_CYCLES  = 33
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_zero,
    output logic [31:0] o_hi_out,
    output logic [31:0] o_lo_out,
    output logic        o_unit_reset,
    output logic        o_mult_start,
    output logic [31:0] o_mult_a,
    output logic [31:0] o_mult_b,
    input  logic [31:0] i_mult_hi,
    input  logic [31:0] i_mult_lo,
    output logic        o_div_start,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    input  logic [31:0] i_div_hi,
    input  logic [31:0] i_div_lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
`ifdef MULDIV_DIVZERO_CHECK_EN
        S_DZERO,
`endif
        S_COMMIT
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_sel_div;   // 1: current long op runs on the divider
    logic            r_mt_done;   // MTHI/MTLO completion pulse
    logic [31:0]     r_hi, r_lo;
    logic [31:0]     r_mult_a, r_mult_b, r_div_a, r_div_b;

    logic w_accept, w_is_mult, w_is_div, w_is_mthi, w_is_mtlo, w_dz, w_last;

    assign w_is_mult = (i_op == OP_MULT);
    assign w_is_div  = (i_op == OP_DIV);
    assign w_is_mthi = (i_op == OP_MTHI);
    assign w_is_mtlo = (i_op == OP_MTLO);
    // Illegal codes never accept, so they leave no trace at all.
    assign w_accept  = i_op_valid && (r_state == S_IDLE) &&
                       (w_is_mult || w_is_div || w_is_mthi || w_is_mtlo);
`ifdef MULDIV_DIVZERO_CHECK_EN
    assign w_dz      = w_is_div && (i_rt_val == 32'd0);
`else
    assign w_dz      = 1'b0;
`endif
    assign w_last    = r_sel_div ? (r_cnt == DIV_LAST) : (r_cnt == MULT_LAST);

    assign o_unit_reset = ~i_reset;
    assign o_hi_out     = r_hi;
    assign o_lo_out     = r_lo;
    assign o_mult_a     = r_mult_a;
    assign o_mult_b     = r_mult_b;
    assign o_div_a      = r_div_a;
    assign o_div_b      = r_div_b;

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_is_mult || w_is_div)) begin
`ifdef MULDIV_DIVZERO_CHECK_EN
                    w_next = w_dz ? S_DZERO : S_START;
`else
                    w_next = S_START;
`endif
                end
            end
            S_START:  w_next = S_WAIT;
            S_WAIT:   if (w_last) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
`ifdef MULDIV_DIVZERO_CHECK_EN
            S_DZERO:  w_next = S_IDLE;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_mult_start = (r_state == S_START) && !r_sel_div;
        o_div_start  = (r_state == S_START) &&  r_sel_div;
        o_done       = (r_state == S_COMMIT) || r_mt_done;
        o_div_zero   = 1'b0;
`ifdef MULDIV_DIVZERO_CHECK_EN
        if (r_state == S_DZERO) begin
            o_done     = 1'b1;
            o_div_zero = 1'b1;
        end
`endif
    end

    // Operand latches, latency counter and HI/LO commit
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_cnt     <= '0;
            r_sel_div <= 1'b0;
            r_mt_done <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mult_a  <= '0;
            r_mult_b  <= '0;
            r_div_a   <= '0;
            r_div_b   <= '0;
        end else begin
            r_mt_done <= w_accept && (w_is_mthi || w_is_mtlo);
            if (w_accept && w_is_mult) begin
                r_mult_a  <= i_rs_val;
                r_mult_b  <= i_rt_val;
                r_sel_div <= 1'b0;
            end
            if (w_accept && w_is_div && !w_dz) begin
                r_div_a   <= i_rs_val;
                r_div_b   <= i_rt_val;
                r_sel_div <= 1'b1;
            end
            if (w_accept && w_is_mthi) r_hi <= i_rs_val;
            if (w_accept && w_is_mtlo) r_lo <= i_rs_val;
            if (r_state == S_START)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + CW'(1);
            // Result is captured on the edge that enters COMMIT, so HI/LO are
            // already valid while done is high.
            if (r_state == S_WAIT && w_last) begin
                r_hi <= r_sel_div ? i_div_hi : i_mult_hi;
                r_lo <= r_sel_div ? i_div_lo : i_mult_lo;
            end
        end
    end
endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Sequencing controller for the shared MULT/DIV datapath. It accepts one HI/LO-class instruction at a time from the control unit and latches the operands. It then pulses the start input of either the Booth multiplier or the divider and waits a fixed, parameterised number of cycles. Finally it commits the 64-bit result into the architectural HI/LO registers. It holds `busy` to stall the pipeline and owns HI/LO, so MFHI/MFLO read `hi_out`/`lo_out` directly.

## Interface
- `MULT_CYCLES`, default 33: cycles from the `mult_start` sampling edge until `mult_hi`/`mult_lo` are valid.
- `DIV_CYCLES`, default 33: same, for the divider.
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-low.
- `op_valid` in 1: request strobe.
- `op` in 3: 001 MULT, 010 DIV, 011 MTHI, 100 MTLO; other codes are ignored.
- `rs_val` in 32: operand A; also the MTHI/MTLO source.
- `rt_val` in 32: operand B.
- `busy` out 1: high when state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `div_zero` out 1: one-cycle divide-by-zero flag.
- `hi_out` out 32: architectural HI register.
- `lo_out` out 32: architectural LO register.
- `unit_reset` out 1: active-high reset for both units, equal to ~`reset`.
- `mult_start` out 1: multiplier start (`comeco`).
- `mult_a` out 32: latched multiplier operand A.
- `mult_b` out 32: latched multiplier operand B.
- `mult_hi` in 32: multiplier result, high word.
- `mult_lo` in 32: multiplier result, low word.
- `div_start` out 1: divider start.
- `div_a` out 32: latched dividend.
- `div_b` out 32: latched divisor.
- `div_hi` in 32: remainder.
- `div_lo` in 32: quotient.

## Operation
- States: IDLE, START, WAIT, COMMIT, DZERO.
- Acceptance: only when `op_valid` is high, state is IDLE and `op` is legal. Requests arriving while busy are dropped with no side effect; the requester must wait for `busy` low.
- MULT/DIV accept edge:
  - Latch `rs_val`/`rt_val` into `mult_a`/`mult_b` or `div_a`/`div_b`.
  - Record the unit selection.
  - Go to START.
- START:
  - Exactly one of `mult_start`/`div_start` is high for this one cycle.
  - Next state is WAIT, with the cycle counter set to 0.
- WAIT:
  - Counter increments each edge; start outputs are low.
  - When counter = N−1 (N = MULT_CYCLES or DIV_CYCLES), the next edge enters COMMIT.
  - That same edge loads HI/LO from the selected unit: HI←`mult_hi`, LO←`mult_lo` for MULT; HI←`div_hi` (remainder), LO←`div_lo` (quotient) for DIV.
- COMMIT: `done` high for this cycle, then IDLE.
- MTHI/MTLO:
  - Write `rs_val` into HI or LO on the accept edge.
  - State stays IDLE and `busy` stays low.
  - `done` pulses in the following cycle.
  - A new op may be accepted in that same cycle.
- Operand latches hold their value until the next accepted op of the same unit.
- Counter width is ⌈log2(max(MULT_CYCLES, DIV_CYCLES))⌉+1 bits.
- Counter wrap is unreachable, because WAIT exits at N−1.

## Timing
- Reset values:
  - `busy`, `done`, `div_zero`, `mult_start`, `div_start` = 0.
  - `hi_out`, `lo_out`, `mult_a`, `mult_b`, `div_a`, `div_b` = 0.
  - State is IDLE and counter is 0.
- Reset mid-operation: on the next edge the state returns to IDLE, the pending result is discarded and HI/LO are cleared. `unit_reset` is asserted for as long as `reset` is low, which aborts both units.
- Latency, accept edge E0 to `done`:
  - MULT/DIV: `done` is high in the cycle after edge E0+1+N, i.e. N+2 edges after acceptance.
  - MTHI/MTLO: `done` is high in the cycle after E0.
- HI/LO are updated at the edge that asserts `done`, so they are already valid while `done` is high.
- `busy` rises in the cycle after E0 and falls after COMMIT or DZERO.
- An op presented during the COMMIT cycle is ignored, because state ≠ IDLE.
- Simultaneous reset and `op_valid`: reset wins.

## Configuration
- `MULDIV_DIVZERO_CHECK_EN` defined:
  - A DIV with `rt_val` = 0 does not start the divider; the accept edge goes to DZERO.
  - DZERO lasts one cycle, with `done` and `div_zero` both high; HI/LO are unchanged. The next state is IDLE.
- `MULDIV_DIVZERO_CHECK_EN` undefined:
  - DZERO is absent and `div_zero` is tied to 0.
  - A zero divisor takes the normal DIV path, and HI/LO receive whatever the divider outputs.

## Test plan
- MULT, `rs_val`=7, `rt_val`=0xFFFFFFFD, using real MULT with MULT_CYCLES=33. Required: `mult_start` pulses exactly once; `done` occurs 35 edges after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` is high throughout.
- DIV 100/7 against a divider stub. Required: HI=2, LO=14; `done` occurs DIV_CYCLES+2 edges after acceptance; `mult_start` never asserts.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 in the next cycle. Required: both are accepted with `busy` low throughout; `hi_out`/`lo_out` hold those values; two consecutive `done` pulses.
- MULT accepted, then DIV requested while busy. Required: the DIV is dropped, so no `div_start` fires and HI/LO reflect only the MULT.
- DIV with `rt_val`=0, check enabled. Required: `done` and `div_zero` are high one cycle after accept; HI/LO are unchanged; `div_start` stays 0.
- `reset` pulled low mid-WAIT. Required: next edge gives state IDLE, `busy`=0 and HI=LO=0; `unit_reset`=1 while `reset` is low; no `done` pulse.
